// File: rtl/deadlock_mon_pkg.sv
// Shared state encoding and bit helpers for the deadlock token monitor.
package deadlock_mon_pkg;
  localparam int MAX_PROC = 32;

  typedef enum logic {
    ST_SCAN  = 1'b0,
    ST_TOKEN = 1'b1
  } state_t;

  // Keeps only the lowest set bit (two's-complement trick); zero maps to zero.
  function automatic logic [MAX_PROC-1:0] lowest_set(input logic [MAX_PROC-1:0] v);
    return v & (~v + MAX_PROC'(1));
  endfunction
endpackage

// File: rtl/deadlock_stable_cnt.sv
// Per-process saturating blocked-cycle counter; o_stable once it reaches STABLE_CNT.
module deadlock_stable_cnt #(
  parameter int STABLE_CNT = 16
) (
  input  logic dl_clock,
  input  logic dl_reset,
  input  logic i_blocked,
  output logic o_stable
);
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge dl_clock) begin
    if (dl_reset || !i_blocked) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_stable = (r_cnt == CNT_MAX);
endmodule

// File: rtl/deadlock_token_monitor.sv
// Flags stably blocked processes and walks a one-hot token along the wait-for graph.
// Optional token-walk watchdog enabled by DEADLOCK_TOKEN_MONITOR_TIMEOUT_EN.
//   state    | meaning
//   ST_SCAN  | publish processes whose whole dependency set is stably blocked
//   ST_TOKEN | publish the one-hot token holder while it walks the cycle
module deadlock_token_monitor
  import deadlock_mon_pkg::*;
#(
  parameter int PROC_NUM    = 2,
  parameter int STABLE_CNT  = 16,
  parameter int TOK_TIMEOUT = 64
) (
  input  logic                         dl_clock,
  input  logic                         dl_reset,
  input  logic [PROC_NUM-1:0]          proc_blocked,
  input  logic [PROC_NUM*PROC_NUM-1:0] dep_vec,
  input  logic [PROC_NUM-1:0]          origin,
  input  logic                         token_clear,
  output logic [PROC_NUM-1:0]          dl_in_vec,
  output logic                         tok_active,
  output logic                         tok_timeout
);
  state_t              r_state, w_state_nxt;
  logic [PROC_NUM-1:0] r_token, w_token_nxt;
  logic [PROC_NUM-1:0] r_dl_in_vec, w_dl_nxt;
  logic                r_tok_timeout, w_tmo_nxt, w_tmo_hit;
  logic [PROC_NUM-1:0] w_stable, w_scan_vec, w_hold_row, w_cand, w_cand_low, w_origin_1h, w_adv;

  for (genvar gi = 0; gi < PROC_NUM; gi++) begin : g_cnt
    deadlock_stable_cnt #(.STABLE_CNT(STABLE_CNT)) u_cnt (
      .dl_clock  (dl_clock),
      .dl_reset  (dl_reset),
      .i_blocked (proc_blocked[gi]),
      .o_stable  (w_stable[gi])
    );
  end

  // An empty dependency row never qualifies: a process waiting on nobody is not deadlocked.
  always_comb begin
    w_scan_vec = '0;
    w_hold_row = '0;
    for (int i = 0; i < PROC_NUM; i++) begin
      w_scan_vec[i] = w_stable[i] && (|dep_vec[i*PROC_NUM +: PROC_NUM]) &&
                      ((dep_vec[i*PROC_NUM +: PROC_NUM] & ~w_stable) == '0);
      if (r_token[i]) w_hold_row = w_hold_row | dep_vec[i*PROC_NUM +: PROC_NUM];
    end
  end

  assign w_cand      = w_hold_row & w_stable;
  assign w_cand_low  = PROC_NUM'(lowest_set(MAX_PROC'(w_cand)));
  assign w_origin_1h = PROC_NUM'(lowest_set(MAX_PROC'(origin)));
  assign w_adv       = (w_cand != '0) ? w_cand_low : r_token;

`ifdef DEADLOCK_TOKEN_MONITOR_TIMEOUT_EN
  localparam int TW = $clog2(TOK_TIMEOUT + 1);
  logic [TW-1:0] r_tok_cnt;

  always_ff @(posedge dl_clock) begin
    if (dl_reset || r_state != ST_TOKEN) begin
      r_tok_cnt <= '0;
    end else begin
      r_tok_cnt <= r_tok_cnt + TW'(1);
    end
  end

  assign w_tmo_hit = (r_state == ST_TOKEN) && (r_tok_cnt == TW'(TOK_TIMEOUT - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TOK_TIMEOUT > 0);
  assign w_tmo_hit    = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_token_nxt = r_token;
    w_dl_nxt    = '0;
    w_tmo_nxt   = 1'b0;
    case (r_state)
      ST_SCAN: begin
        if (origin != '0 && !token_clear) begin
          w_state_nxt = ST_TOKEN;
          w_token_nxt = w_origin_1h;
          w_dl_nxt    = w_origin_1h;
        end else begin
          w_dl_nxt = w_scan_vec;
        end
      end
      ST_TOKEN: begin
        if (token_clear) begin
          w_state_nxt = ST_SCAN;
          w_token_nxt = '0;
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_SCAN;
          w_token_nxt = '0;
          w_tmo_nxt   = 1'b1;
        end else if (origin != '0) begin
          w_token_nxt = w_origin_1h;
          w_dl_nxt    = w_origin_1h;
        end else begin
          w_token_nxt = w_adv;
          w_dl_nxt    = w_adv;
        end
      end
    endcase
  end

  always_ff @(posedge dl_clock) begin
    if (dl_reset) begin
      r_state       <= ST_SCAN;
      r_token       <= '0;
      r_dl_in_vec   <= '0;
      r_tok_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_token       <= w_token_nxt;
      r_dl_in_vec   <= w_dl_nxt;
      r_tok_timeout <= w_tmo_nxt;
    end
  end

  assign dl_in_vec   = r_dl_in_vec;
  assign tok_active  = (r_state == ST_TOKEN);
  assign tok_timeout = r_tok_timeout;
endmodule

// File: tb/tb_deadlock_token_monitor.sv
// Directed bench for deadlock_token_monitor with an index-based reference model.
module tb_deadlock_token_monitor;
  localparam int P  = 2;
  localparam int SC = 16;
  localparam int TO = 8;
`ifdef DEADLOCK_TOKEN_MONITOR_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic         dl_clock = 1'b0;
  logic         dl_reset = 1'b1;
  logic [P-1:0] proc_blocked = '0;
  logic [P*P-1:0] dep_vec = '0;
  logic [P-1:0] origin = '0;
  logic         token_clear = 1'b0;
  logic [P-1:0] dl_in_vec;
  logic         tok_active;
  logic         tok_timeout;

  int n_pass = 0;
  int n_total = 0;

  always #5 dl_clock = ~dl_clock;

  deadlock_token_monitor #(.PROC_NUM(P), .STABLE_CNT(SC), .TOK_TIMEOUT(TO)) dut (
    .dl_clock     (dl_clock),
    .dl_reset     (dl_reset),
    .proc_blocked (proc_blocked),
    .dep_vec      (dep_vec),
    .origin       (origin),
    .token_clear  (token_clear),
    .dl_in_vec    (dl_in_vec),
    .tok_active   (tok_active),
    .tok_timeout  (tok_timeout)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int first_idx(input logic [P-1:0] v);
    int r = -1;
    for (int k = P - 1; k >= 0; k--) if (v[k]) r = k;
    return r;
  endfunction

  // Reference model: per-process blocked-cycle counts, token as an index.
  int           m_cnt [P];
  bit           m_tok = 1'b0;
  int           m_holder = -1;
  int           m_tok_cycles = 0;
  logic [P-1:0] m_vec = '0;
  bit           m_tmo = 1'b0;

  always @(posedge dl_clock) begin
    logic [P-1:0] stab;
    logic [P-1:0] cand;
    int           deps;
    bit           ok;
    if (dl_reset) begin
      for (int i = 0; i < P; i++) m_cnt[i] = 0;
      m_tok = 1'b0; m_holder = -1; m_vec = '0; m_tmo = 1'b0; m_tok_cycles = 0;
    end else begin
      for (int i = 0; i < P; i++) stab[i] = (m_cnt[i] == SC);
      m_tmo = 1'b0;
      m_vec = '0;
      if (!m_tok) begin
        if (origin != '0 && !token_clear) begin
          m_tok = 1'b1; m_tok_cycles = 0; m_holder = first_idx(origin);
        end else begin
          for (int i = 0; i < P; i++) begin
            deps = 0; ok = 1'b1;
            for (int j = 0; j < P; j++) if (dep_vec[i*P+j]) begin
              deps++;
              if (!stab[j]) ok = 1'b0;
            end
            m_vec[i] = stab[i] && (deps > 0) && ok;
          end
        end
      end else if (token_clear) begin
        m_tok = 1'b0;
      end else begin
        m_tok_cycles++;
        if (TMO_EN && m_tok_cycles == TO) begin
          m_tok = 1'b0; m_tmo = 1'b1;
        end else if (origin != '0) begin
          m_holder = first_idx(origin);
        end else begin
          for (int j = 0; j < P; j++) cand[j] = dep_vec[m_holder*P+j] && stab[j];
          if (first_idx(cand) >= 0) m_holder = first_idx(cand);
        end
      end
      if (m_tok) m_vec[m_holder] = 1'b1;
      for (int i = 0; i < P; i++)
        m_cnt[i] = proc_blocked[i] ? ((m_cnt[i] < SC) ? m_cnt[i] + 1 : SC) : 0;
    end
    #1;
    check("cyc_vec", int'(dl_in_vec), int'(m_vec));
    check("cyc_active", int'(tok_active), int'(m_tok));
    check("cyc_tmo", int'(tok_timeout), int'(m_tmo));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    repeat (2) @(negedge dl_clock);
    check("rst_vec", int'(dl_in_vec), 0);
    check("rst_active", int'(tok_active), 0);
    check("rst_tmo", int'(tok_timeout), 0);
    dl_reset = 1'b0;

    // Mutual wait: row0 = 2'b10, row1 = 2'b01
    dep_vec = 4'b0110; proc_blocked = 2'b11;
    repeat (16) @(negedge dl_clock);
    check("a_pre17", int'(dl_in_vec), 0);
    @(negedge dl_clock);
    check("a_at17", int'(dl_in_vec), 3);

    proc_blocked = 2'b00;
    repeat (2) @(negedge dl_clock);
    check("b_cleared", int'(dl_in_vec), 0);
    proc_blocked = 2'b11;
    repeat (9) @(negedge dl_clock);
    proc_blocked = 2'b10;
    @(negedge dl_clock);
    proc_blocked = 2'b11;
    repeat (16) @(negedge dl_clock);
    check("b_restart", int'(dl_in_vec), 0);
    @(negedge dl_clock);
    check("b_reflag", int'(dl_in_vec), 3);

    origin = 2'b01;
    @(negedge dl_clock);
    check("c_tok0", int'(dl_in_vec), 1);
    check("c_active", int'(tok_active), 1);
    origin = 2'b00;
    @(negedge dl_clock);
    check("c_tok1", int'(dl_in_vec), 2);
    @(negedge dl_clock);
    check("c_tok2", int'(dl_in_vec), 1);
    token_clear = 1'b1;
    @(negedge dl_clock);
    check("c_clr_vec", int'(dl_in_vec), 0);
    check("c_clr_active", int'(tok_active), 0);
    token_clear = 1'b0;
    @(negedge dl_clock);
    check("c_rescan", int'(dl_in_vec), 3);

    origin = 2'b01;
    @(negedge dl_clock);
    origin = 2'b10; token_clear = 1'b1;
    @(negedge dl_clock);
    check("d_prio_vec", int'(dl_in_vec), 0);
    check("d_prio_active", int'(tok_active), 0);
    origin = 2'b00; token_clear = 1'b0;
    @(negedge dl_clock);

    origin = 2'b11;
    @(negedge dl_clock);
    check("e_lowbit", int'(dl_in_vec), 1);
    origin = 2'b00;
    @(negedge dl_clock);
    check("e_adv", int'(dl_in_vec), 2);
    token_clear = 1'b1;
    @(negedge dl_clock);
    token_clear = 1'b0;
    @(negedge dl_clock);

    // Process 0 waits on nobody
    dep_vec = 4'b0100;
    @(negedge dl_clock);
    check("f_zero_row", int'(dl_in_vec), 2);
    origin = 2'b01;
    @(negedge dl_clock);
    check("f_tok", int'(dl_in_vec), 1);
    origin = 2'b00;
    @(negedge dl_clock);
    check("f_hold", int'(dl_in_vec), 1);
    token_clear = 1'b1;
    @(negedge dl_clock);
    token_clear = 1'b0; dep_vec = 4'b0110;
    @(negedge dl_clock);
    check("f_rescan", int'(dl_in_vec), 3);

    origin = 2'b10;
    @(negedge dl_clock);
    check("g_tok", int'(dl_in_vec), 2);
    origin = 2'b00;
    @(negedge dl_clock);
    check("g_adv", int'(dl_in_vec), 1);
    dl_reset = 1'b1;
    @(negedge dl_clock);
    check("g_rst_vec", int'(dl_in_vec), 0);
    check("g_rst_active", int'(tok_active), 0);
    check("g_rst_tmo", int'(tok_timeout), 0);
    dl_reset = 1'b0;
    for (int n = 0; n < 16; n++) begin
      @(negedge dl_clock);
      check("g_quiet", int'(dl_in_vec), 0);
    end
    @(negedge dl_clock);
    check("g_reflag", int'(dl_in_vec), 3);

    origin = 2'b01;
    @(negedge dl_clock);
    origin = 2'b00;
`ifdef DEADLOCK_TOKEN_MONITOR_TIMEOUT_EN
    repeat (7) @(negedge dl_clock);
    check("h_pre_tmo", int'(tok_timeout), 0);
    check("h_pre_active", int'(tok_active), 1);
    @(negedge dl_clock);
    check("h_tmo", int'(tok_timeout), 1);
    check("h_tmo_active", int'(tok_active), 0);
    check("h_tmo_vec", int'(dl_in_vec), 0);
    @(negedge dl_clock);
    check("h_tmo_pulse", int'(tok_timeout), 0);
    check("h_rescan", int'(dl_in_vec), 3);
`else
    repeat (10) @(negedge dl_clock);
    check("h_no_tmo", int'(tok_timeout), 0);
    check("h_still_active", int'(tok_active), 1);
    token_clear = 1'b1;
    @(negedge dl_clock);
    token_clear = 1'b0;
    check("h_clr_active", int'(tok_active), 0);
`endif
    @(negedge dl_clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/deadlock_token_monitor.md
DEADLOCK_TOKEN_MONITOR -- requirements
Module: deadlock_token_monitor

Interface
REQ-001 SHALL have parameter PROC_NUM, default 2, number of dataflow processes monitored.
REQ-002 SHALL have parameter STABLE_CNT, default 16, cycles a process must stay blocked before it is flagged.
REQ-003 SHALL have parameter TOK_TIMEOUT, default 64, token-walk watchdog limit in cycles (used only under REQ-028).
REQ-004 SHALL have port dl_clock input 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port dl_reset input 1, synchronous, active-high reset.
REQ-006 SHALL have port proc_blocked input PROC_NUM, bit i high means process i is stalled on a channel.
REQ-007 SHALL have port dep_vec input PROC_NUM*PROC_NUM, slice [i*PROC_NUM +: PROC_NUM] lists the processes that process i waits on.
REQ-008 SHALL have port origin input PROC_NUM, one-hot cycle start from the report unit, zero when idle.
REQ-009 SHALL have port token_clear input 1, one-cycle pulse meaning the token has returned to origin.
REQ-010 SHALL have port dl_in_vec output PROC_NUM, blocked-process vector to the report unit.
REQ-011 SHALL have port tok_active output 1, high while in ST_TOKEN.
REQ-012 SHALL have port tok_timeout output 1, one-cycle pulse on watchdog expiry (REQ-028 only).

Function
REQ-013 SHALL implement a 2-state FSM, ST_SCAN and ST_TOKEN; reset state ST_SCAN.
REQ-014 SHALL keep one saturating counter of width clog2(STABLE_CNT+1) per process: +1 while proc_blocked[i]=1, cleared to 0 in the same cycle proc_blocked[i]=0, holding at STABLE_CNT.
REQ-015 SHALL, in ST_SCAN, register dl_in_vec[i]=1 when counter i == STABLE_CNT and every set bit of dep row i has its counter == STABLE_CNT; 1-cycle latency from the qualifying condition.
REQ-016 SHALL treat an all-zero dep row as unsatisfied: dl_in_vec[i] stays 0.
REQ-017 SHALL, on any cycle with origin != 0 (ST_SCAN or ST_TOKEN), load token <= origin and enter or stay in ST_TOKEN.
REQ-018 SHALL, in ST_TOKEN, drive dl_in_vec = token, one-hot.
REQ-019 SHALL advance token each cycle to the lowest-index set bit of (dep row of holder & current blocked-stable vector).
REQ-020 SHALL hold token unchanged when no qualifying dependency exists.
REQ-021 SHALL, on token_clear, zero the token and return to ST_SCAN next cycle; dl_in_vec = 0 that cycle.
REQ-022 SHALL give token_clear priority over a simultaneous origin when both occur.
REQ-023 SHALL treat a non-one-hot origin as its lowest set bit.
REQ-024 SHALL ignore token_clear in ST_SCAN.

Reset
REQ-025 SHALL, while dl_reset=1 at a rising edge, set FSM=ST_SCAN, all counters=0, token=0, dl_in_vec=0, tok_active=0, tok_timeout=0.
REQ-026 SHALL, when reset is asserted mid-walk, abandon the token and require STABLE_CNT fresh blocked cycles before reflagging.

Configuration
REQ-027 SHALL, without DEADLOCK_TOKEN_MONITOR_TIMEOUT_EN, have no watchdog and tie tok_timeout to 0.
REQ-028 SHALL, with DEADLOCK_TOKEN_MONITOR_TIMEOUT_EN, count ST_TOKEN cycles; reaching TOK_TIMEOUT pulses tok_timeout, zeros the token, and returns to ST_SCAN; the count clears on entry to ST_TOKEN.

Structure
REQ-029 SHALL place the state encoding (ST_SCAN=1'b0, ST_TOKEN=1'b1) and the lowest-set-bit function in shared package deadlock_mon_pkg.
REQ-030 SHALL instantiate PROC_NUM copies of sub-module deadlock_stable_cnt (one counter plus stable flag each).

Verification
REQ-031 SHALL cover: PROC_NUM=2, proc_blocked=2'b11, dep rows {2'b10, 2'b01} held 17 cycles -> dl_in_vec=2'b11 from cycle 17.
REQ-032 SHALL cover: proc_blocked[0] dropped at cycle 10 of 16 -> dl_in_vec stays 2'b00; counter restarts from 0.
REQ-033 SHALL cover: both processes stable, origin=2'b01 for 1 cycle -> dl_in_vec 2'b01 then 2'b10 then 2'b01; token_clear -> 2'b00 next cycle, tok_active=0.
REQ-034 SHALL cover: token_clear and origin=2'b10 in the same cycle -> ST_SCAN, token=0.
REQ-035 SHALL cover: dl_reset mid-walk -> all outputs 0 next cycle and dl_in_vec=0 for 16 cycles.
REQ-036 SHALL cover: with DEADLOCK_TOKEN_MONITOR_TIMEOUT_EN, TOK_TIMEOUT=8, no token_clear -> tok_timeout pulse 8 cycles after entering ST_TOKEN, then ST_SCAN.
